qspi_sram_responder: RTL and testbench

- Synthesizable QSPI responder (target side) for the bfCPU QSPI initiator; on the FPGA board it stands in for an external quad SPI SRAM.
- Oversamples QSPI_CS_N, QSPI_SCK and QSPI_SIO_I in the CLK domain and decodes quad-mode command/address frames.
- Serves reads and writes from a synchronous byte-wide RAM port (block RAM outside this module).
- Its pin-side signals connect to the tri-state buffers in the FPGA top.

---
 rtl/qspi_sram_responder_if.sv | 27 ++
 rtl/qspi_sram_responder.sv | 204 ++++++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_sram_responder_if.sv
// Pin-side QSPI signals and the byte-wide RAM port of the QSPI SRAM responder.
// The slave modport is the responder's view; the master modport is the pads/RAM side.
interface qspi_sram_responder_if #(
  parameter int ADDR_W = 17
);
  logic              QSPI_CS_N;
  logic              QSPI_SCK;
  logic [3:0]        QSPI_SIO_I;
  logic [3:0]        QSPI_SIO_O;
  logic [3:0]        QSPI_SIO_E;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic              MEM_WE;
  logic [7:0]        MEM_WDATA;
  logic [7:0]        MEM_RDATA;
  logic              BUSY;

  modport slave (
    input  QSPI_CS_N, QSPI_SCK, QSPI_SIO_I, MEM_RDATA,
    output QSPI_SIO_O, QSPI_SIO_E, MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, BUSY
  );

  modport master (
    output QSPI_CS_N, QSPI_SCK, QSPI_SIO_I, MEM_RDATA,
    input  QSPI_SIO_O, QSPI_SIO_E, MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, BUSY
  );
endinterface

// File: rtl/qspi_sram_responder.sv
// Quad-SPI target that emulates an external SRAM: oversamples the QSPI pins in the
// CLK domain, decodes 0xEB (quad read) / 0x38 (quad write) frames and serves a byte RAM.
module qspi_sram_responder #(
  parameter int ADDR_W = 17,
  parameter int DUMMY  = 4
) (
  input logic                  CLK,
  input logic                  RES_N,
  qspi_sram_responder_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR_RD = 3'd2;
  localparam logic [2:0] S_ADDR_WR = 3'd3;
  localparam logic [2:0] S_DUMMY   = 3'd4;
  localparam logic [2:0] S_RDATA   = 3'd5;
  localparam logic [2:0] S_WDATA   = 3'd6;
  localparam logic [2:0] S_IGNORE  = 3'd7;

  logic [1:0] cs_sync_q, sck_sync_q, valid_q;
  logic [3:0] sio_meta_q, sio_sync_q;
  logic       sck_prev_q;
  logic       cs_high, sck_rise, sck_fall;

  // CS_N syncs reset high so BUSY is low and no frame is seen during reset.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      cs_sync_q  <= 2'b11;
      sck_sync_q <= 2'b00;
      sio_meta_q <= 4'h0;
      sio_sync_q <= 4'h0;
      sck_prev_q <= 1'b0;
      valid_q    <= 2'b00;
    end else begin
      cs_sync_q  <= {cs_sync_q[0], bus.QSPI_CS_N};
      sck_sync_q <= {sck_sync_q[0], bus.QSPI_SCK};
      sio_meta_q <= bus.QSPI_SIO_I;
      sio_sync_q <= sio_meta_q;
      sck_prev_q <= sck_sync_q[1];
      valid_q    <= {valid_q[0], 1'b1};
    end
  end

  assign cs_high  = cs_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;

  logic [2:0]        state_q, state_d;
  logic [2:0]        nib_q, nib_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic [ADDR_W-5:0] shift_q, shift_d;
  logic [ADDR_W-1:0] shift_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rbyte_q, rbyte_d, wdata_q, wdata_d;
  logic [3:0]        sio_o_q, sio_o_d, sio_e_q, sio_e_d;
  logic              rlo_q, rlo_d, cap_q, cap_d, winc_q, winc_d;
  logic              re_q, re_d, we_q, we_d, armed_q, armed_d;

  assign shift_in = {shift_q, sio_sync_q};

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    dcnt_d  = dcnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    rbyte_d = rbyte_q;
    wdata_d = wdata_q;
    sio_o_d = sio_o_q;
    sio_e_d = sio_e_q;
    rlo_d   = rlo_q;
    cap_d   = re_q;
    winc_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    // Only a CS_N high seen after reset arms the block, so a frame already running is skipped.
    armed_d = armed_q | (valid_q[1] & cs_high);

    if (winc_q) addr_d = addr_q + ADDR_W'(1);
    if (cap_q)  rbyte_d = bus.MEM_RDATA;

    if (cs_high && state_q != S_IDLE) begin
      state_d = S_IDLE;
      nib_d   = 3'd0;
      dcnt_d  = 4'd0;
      rlo_d   = 1'b0;
      sio_o_d = 4'h0;
      sio_e_d = 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          nib_d = 3'd0;
          if (!cs_high && armed_q) state_d = S_CMD;
        end
        S_CMD: if (sck_rise) begin
          shift_d = shift_in[ADDR_W-5:0];
          nib_d   = nib_q + 3'd1;
          if (nib_q == 3'd1) begin
            nib_d = 3'd0;
            case (shift_in[7:0])
              8'hEB:   state_d = S_ADDR_RD;
              8'h38:   state_d = S_ADDR_WR;
              default: state_d = S_IGNORE;
            endcase
          end
        end
        S_ADDR_RD, S_ADDR_WR: if (sck_rise) begin
          shift_d = shift_in[ADDR_W-5:0];
          nib_d   = nib_q + 3'd1;
          if (nib_q == 3'd5) begin
            nib_d  = 3'd0;
            addr_d = shift_in;
            if (state_q == S_ADDR_RD) begin
              re_d    = 1'b1;
              dcnt_d  = 4'd0;
              state_d = S_DUMMY;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_DUMMY: if (sck_rise) begin
          if (dcnt_q == 4'(DUMMY - 1)) begin
            rlo_d   = 1'b0;
            state_d = S_RDATA;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        // The next byte is fetched as the low nibble goes out and lands two CLKs later.
        S_RDATA: if (sck_fall) begin
          sio_e_d = 4'hF;
          if (!rlo_q) begin
            sio_o_d = rbyte_q[7:4];
            rlo_d   = 1'b1;
          end else begin
            sio_o_d = rbyte_q[3:0];
            rlo_d   = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
            re_d    = 1'b1;
          end
        end
        S_WDATA: if (sck_rise) begin
          shift_d = shift_in[ADDR_W-5:0];
          if (nib_q == 3'd0) begin
            nib_d = 3'd1;
          end else begin
            nib_d   = 3'd0;
            we_d    = 1'b1;
            wdata_d = shift_in[7:0];
            winc_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= S_IDLE;
      nib_q   <= 3'd0;
      dcnt_q  <= 4'd0;
      shift_q <= '0;
      addr_q  <= '0;
      rbyte_q <= 8'h00;
      wdata_q <= 8'h00;
      sio_o_q <= 4'h0;
      sio_e_q <= 4'h0;
      rlo_q   <= 1'b0;
      cap_q   <= 1'b0;
      winc_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      dcnt_q  <= dcnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      rbyte_q <= rbyte_d;
      wdata_q <= wdata_d;
      sio_o_q <= sio_o_d;
      sio_e_q <= sio_e_d;
      rlo_q   <= rlo_d;
      cap_q   <= cap_d;
      winc_q  <= winc_d;
      re_q    <= re_d;
      we_q    <= we_d;
      armed_q <= armed_d;
    end
  end

  assign bus.QSPI_SIO_O = sio_o_q;
  assign bus.QSPI_SIO_E = sio_e_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.MEM_RE     = re_q;
  assign bus.MEM_WE     = we_q;
  assign bus.MEM_WDATA  = wdata_q;
  assign bus.BUSY       = ~cs_sync_q[1];

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: a QSPI initiator model plus a behavioural RAM,
// with expected RAM writes and read nibbles queued as frames are driven.
`timescale 1ns/1ps
module tb_qspi_sram_responder;

  localparam int ADDR_W = 17;
  localparam int DUMMY  = 4;
  localparam int HALF   = 6;

  logic clk;
  logic resN;
  int   testsRun;
  int   failCnt;
  int   reCount;

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W+7:0] wrQ [$];
  logic [3:0]        rdQ [$];

  qspi_sram_responder_if #(.ADDR_W(ADDR_W)) qif ();

  qspi_sram_responder #(.ADDR_W(ADDR_W), .DUMMY(DUMMY)) dut (
    .CLK   (clk),
    .RES_N (resN),
    .bus   (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: read data valid the cycle after MEM_RE.
  always @(posedge clk) begin
    if (qif.MEM_WE) ram[qif.MEM_ADDR] <= qif.MEM_WDATA;
    if (qif.MEM_RE) qif.MEM_RDATA <= ram[qif.MEM_ADDR];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (resN) begin
      if (qif.MEM_RE) reCount++;
      if (qif.MEM_RE || qif.MEM_WE)
        checkOutput("re_we_exclusive", 32'(qif.MEM_RE & qif.MEM_WE), 32'd0);
      if (qif.MEM_WE) begin
        logic [31:0] exp;
        exp = (wrQ.size() != 0) ? 32'(wrQ.pop_front()) : 32'hFFFF_FFFF;
        checkOutput("mem_write", 32'({qif.MEM_ADDR, qif.MEM_WDATA}), exp);
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendNibble(input logic [3:0] n);
    qif.QSPI_SIO_I = n;
    waitClk(HALF);
    qif.QSPI_SCK = 1'b1;
    waitClk(HALF);
    qif.QSPI_SCK = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendNibble(b[7:4]);
    sendNibble(b[3:0]);
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr);
    qif.QSPI_CS_N = 1'b0;
    waitClk(HALF);
    sendByte(cmd);
    for (int i = 0; i < 6; i++) sendNibble(addr[23-4*i -: 4]);
  endtask

  task automatic endFrame();
    waitClk(HALF);
    qif.QSPI_CS_N  = 1'b1;
    qif.QSPI_SIO_I = 4'h0;
    waitClk(10);
  endtask

  task automatic dummyClocks();
    for (int i = 0; i < DUMMY; i++) begin
      waitClk(HALF);
      checkOutput("dummy_sio_e", 32'(qif.QSPI_SIO_E), 32'h0);
      qif.QSPI_SCK = 1'b1;
      waitClk(HALF);
      qif.QSPI_SCK = 1'b0;
    end
  endtask

  task automatic readData(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] exp;
      waitClk(HALF);
      exp = (rdQ.size() != 0) ? rdQ.pop_front() : 4'hX;
      checkOutput("rd_sio_e", 32'(qif.QSPI_SIO_E), 32'hF);
      checkOutput("rd_nibble", 32'(qif.QSPI_SIO_O), 32'(exp));
      qif.QSPI_SCK = 1'b1;
      waitClk(HALF);
      qif.QSPI_SCK = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected frame completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int reBefore;
    testsRun = 0;
    failCnt  = 0;
    reCount  = 0;
    resN           = 1'b0;
    qif.QSPI_CS_N  = 1'b0;
    qif.QSPI_SCK   = 1'b0;
    qif.QSPI_SIO_I = 4'h0;
    qif.MEM_RDATA  = 8'h00;

    // Reset held while an initiator is already clocking a frame.
    for (int i = 0; i < 4; i++) sendNibble(4'hF);
    checkOutput("rst_sio_e", 32'(qif.QSPI_SIO_E), 32'h0);
    checkOutput("rst_sio_o", 32'(qif.QSPI_SIO_O), 32'h0);
    checkOutput("rst_mem_we", 32'(qif.MEM_WE), 32'h0);
    checkOutput("rst_mem_re", 32'(qif.MEM_RE), 32'h0);
    checkOutput("rst_busy", 32'(qif.BUSY), 32'h0);
    checkOutput("rst_mem_addr", 32'(qif.MEM_ADDR), 32'h0);

    // Release mid-frame: this write must be ignored until CS_N cycles high.
    resN = 1'b1;
    waitClk(4);
    sendByte(8'h38);
    for (int i = 0; i < 6; i++) sendNibble(4'h0);
    sendByte(8'h77);
    checkOutput("busy_stale_frame", 32'(qif.BUSY), 32'h1);
    endFrame();
    checkOutput("busy_idle", 32'(qif.BUSY), 32'h0);

    // Two-byte write at 0x10.
    wrQ.push_back({17'h00010, 8'hA5});
    wrQ.push_back({17'h00011, 8'h3C});
    applyStimulus(8'h38, 24'h000010);
    sendByte(8'hA5);
    sendByte(8'h3C);
    checkOutput("busy_frame", 32'(qif.BUSY), 32'h1);
    endFrame();
    checkOutput("write_drained", 32'(wrQ.size()), 32'd0);

    // Read the bytes back.
    rdQ.push_back(4'hA); rdQ.push_back(4'h5);
    rdQ.push_back(4'h3); rdQ.push_back(4'hC);
    applyStimulus(8'hEB, 24'h000010);
    dummyClocks();
    readData(4);
    endFrame();
    checkOutput("sio_e_after_read", 32'(qif.QSPI_SIO_E), 32'h0);

    // Address wrap on write.
    wrQ.push_back({17'h1FFFF, 8'h11});
    wrQ.push_back({17'h00000, 8'h22});
    applyStimulus(8'h38, 24'h01FFFF);
    sendByte(8'h11);
    sendByte(8'h22);
    endFrame();
    checkOutput("wrap_drained", 32'(wrQ.size()), 32'd0);

    // Aborts: one data nibble, then mid-address. Nothing may be written.
    applyStimulus(8'h38, 24'h000100);
    sendNibble(4'h5);
    endFrame();
    qif.QSPI_CS_N = 1'b0;
    waitClk(HALF);
    sendByte(8'h38);
    for (int i = 0; i < 3; i++) sendNibble(4'h1);
    endFrame();

    rdQ.push_back(4'h2); rdQ.push_back(4'h2);
    applyStimulus(8'hEB, 24'h000000);
    dummyClocks();
    readData(2);
    endFrame();

    // Illegal command followed by eight clocks.
    reBefore = reCount;
    qif.QSPI_CS_N = 1'b0;
    waitClk(HALF);
    sendByte(8'h9F);
    for (int i = 0; i < 8; i++) begin
      waitClk(HALF);
      checkOutput("illegal_sio_e", 32'(qif.QSPI_SIO_E), 32'h0);
      qif.QSPI_SIO_I = 4'(i);
      qif.QSPI_SCK = 1'b1;
      waitClk(HALF);
      qif.QSPI_SCK = 1'b0;
    end
    endFrame();
    checkOutput("illegal_no_re", 32'(reCount), 32'(reBefore));

    // Read across the address wrap.
    rdQ.push_back(4'h1); rdQ.push_back(4'h1);
    rdQ.push_back(4'h2); rdQ.push_back(4'h2);
    applyStimulus(8'hEB, 24'h01FFFF);
    dummyClocks();
    readData(4);
    endFrame();

    checkOutput("final_wr_queue", 32'(wrQ.size()), 32'd0);
    checkOutput("final_rd_queue", 32'(rdQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
